count_seq_decoder: RTL and testbench
====================================

COUNT_SEQ_DECODER -- requirements
Module: count_seq_decoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on its rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: in_valid  in  1  in_count sample qualifier.
REQ-004 SHALL have ports: in_count  in  4  observed odd/even up/down counter value.
REQ-005 SHALL have ports: dir  out  1  recovered direction; 1 = up (F=1), 0 = down.
REQ-006 SHALL have ports: par  out  1  recovered lane mode; 1 = even lane (P=1), 0 = odd lane.
REQ-007 SHALL have ports: locked  out  1  two consecutive legal steps seen.
REQ-008 SHALL have ports: seq_err  out  1  one-cycle pulse on illegal step.
REQ-009 SHALL have ports: mode_chg  out  1  one-cycle pulse when dir or par changes while locked.
REQ-010 SHALL have ports: err_cnt  out  8  saturating illegal-step count.
REQ-011 SHALL use one clock (clk) and an asynchronous, active-low reset (rst_n); fixed.

Function
REQ-012 SHALL act only on cycles with in_valid=1; all state holds when in_valid=0; gaps are not errors.
REQ-013 SHALL compute delta = (in_count - prev) mod 16, 4-bit wrap, prev = last valid sample.
REQ-014 SHALL classify delta: 1 or 2 -> legal up; 15 or 14 -> legal down; 0 and 3..13 -> illegal.
REQ-015 SHALL, on a legal step, take par = ~in_count[0] and dir = 1 for up, 0 for down.
REQ-016 SHALL use FSM states EMPTY, ACQ1, ACQ2, LOCK.
REQ-017 SHALL transition from EMPTY to ACQ1 on any valid sample (store prev), with no error check.
REQ-018 SHALL transition from ACQ1: legal -> ACQ2; illegal -> ACQ1 with seq_err.
REQ-019 SHALL transition from ACQ2: legal -> LOCK; illegal -> ACQ1 with seq_err.
REQ-020 SHALL, in LOCK: legal stays LOCK; illegal -> ACQ1 with seq_err.
REQ-021 SHALL store prev = in_count on every valid sample in all states, including illegal ones.
REQ-022 SHALL drive locked=1 iff state == LOCK.
REQ-023 SHALL register dir/par, updating them on legal steps only and holding them otherwise.
REQ-024 SHALL register all outputs, with one-cycle latency from the valid sample to the output update.
REQ-025 SHALL pulse mode_chg only in LOCK, when the new legal step's (dir,par) differs from the held value.
REQ-026 SHALL treat wrap-around steps (15->1 up, 0->14 down, 15->0 up, 1->15 down) as legal.
REQ-027 SHALL increment err_cnt on each seq_err and saturate it at 255.

Reset
REQ-028 SHALL, on rst_n low, immediately enter state EMPTY and set prev=0, dir=0, par=0, locked=0, seq_err=0, mode_chg=0, err_cnt=0.
REQ-029 SHALL discard any partially acquired lock when reset asserts mid-operation; the first valid sample after release only loads prev.

Configuration
REQ-030 SHALL compile err_cnt logic only with COUNT_SEQ_DECODER_ERRCNT_EN defined; without it, err_cnt is constant 0 with no register, and all other behaviour is identical.

Structure
REQ-031 SHALL place the FSM state enum, DELTA_UP1=1, DELTA_UP2=2, DELTA_DN1=15 and DELTA_DN2=14 in package count_seq_pkg.
REQ-032 SHALL implement delta classification as combinational sub-module count_delta_classify (prev, cur -> legal, up).

Verification
REQ-033 SHALL cover: valid stream 0,1,3,5 -> locked=1 after the sample 3 is processed; dir=1, par=0; no seq_err.
REQ-034 SHALL cover: stream 8,6,4,2,0,14 -> locked, dir=0, par=1; wrap 0->14 gives no error.
REQ-035 SHALL cover: locked on 1,3,5, then 6 -> legal step (delta 1), mode_chg=1, par=1.
REQ-036 SHALL cover: locked on 1,3,5, then 9 -> seq_err pulse, locked=0, err_cnt=1; then 11,13 -> relock.
REQ-037 SHALL cover: 300 illegal steps (alternating 0,8) -> err_cnt=255 with the macro defined, 0 without.
REQ-038 SHALL cover: rst_n low between the samples 3 and 5, then 5,7 -> no lock until a further legal step, err_cnt=0.

Source files
------------

// File: rtl/count_seq_pkg.sv
// Shared types and constants for the odd/even up/down counter sequence decoder.
//   state_t          : acquisition/lock FSM states
//   DELTA_*          : legal 4-bit step deltas (mod 16)
//   CNT_W / ERR_W    : observed counter width / error counter width
package count_seq_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 8;

  localparam logic [CNT_W-1:0] DELTA_UP1 = 4'd1;
  localparam logic [CNT_W-1:0] DELTA_UP2 = 4'd2;
  localparam logic [CNT_W-1:0] DELTA_DN1 = 4'd15;
  localparam logic [CNT_W-1:0] DELTA_DN2 = 4'd14;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ACQ1  = 2'd1,
    ST_ACQ2  = 2'd2,
    ST_LOCK  = 2'd3
  } state_t;

endpackage

// File: rtl/count_delta_classify.sv
// Combinational step classifier: delta = (cur - prev) mod 16.
//   prev  : previous valid sample
//   cur   : current sample
//   legal : delta is one of +1, +2, -1, -2
//   up    : delta is +1 or +2 (only meaningful when legal)
module count_delta_classify
  import count_seq_pkg::*;
(
  input  logic [CNT_W-1:0] prev,
  input  logic [CNT_W-1:0] cur,
  output logic             legal,
  output logic             up
);

  logic [CNT_W-1:0] delta;
  logic             down;

  // Natural 4-bit wrap gives the modulo-16 difference.
  assign delta = CNT_W'(cur - prev);
  assign up    = (delta == DELTA_UP1) || (delta == DELTA_UP2);
  assign down  = (delta == DELTA_DN1) || (delta == DELTA_DN2);
  assign legal = up || down;

endmodule

// File: rtl/count_seq_decoder.sv
// Recovers direction and lane parity from an observed odd/even up/down
// counter stream, tracks lock after two consecutive legal steps, and flags
// illegal steps.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : sample qualifier for in_count
//   in_count   : observed counter value
//   dir        : 1 = counting up, 0 = counting down
//   par        : 1 = even lane, 0 = odd lane
//   locked     : two consecutive legal steps seen
//   seq_err    : one-cycle pulse on an illegal step
//   mode_chg   : one-cycle pulse when (dir,par) changes while locked
//   err_cnt    : saturating illegal-step count
// Build option: define COUNT_SEQ_DECODER_ERRCNT_EN to implement err_cnt;
// otherwise err_cnt is tied to zero.
module count_seq_decoder
  import count_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [CNT_W-1:0] in_count,
  output logic             dir,
  output logic             par,
  output logic             locked,
  output logic             seq_err,
  output logic             mode_chg,
  output logic [ERR_W-1:0] err_cnt
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] prev_q;
  logic             step_legal;
  logic             step_up;
  logic             dir_d;
  logic             par_d;
  logic             seq_err_d;
  logic             mode_chg_d;

  count_delta_classify u_classify (
    .prev  (prev_q),
    .cur   (in_count),
    .legal (step_legal),
    .up    (step_up)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Next state and next output values
  always_comb begin
    state_d    = state_q;
    dir_d      = dir;
    par_d      = par;
    seq_err_d  = 1'b0;
    mode_chg_d = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_EMPTY: state_d = ST_ACQ1;
        ST_ACQ1, ST_ACQ2, ST_LOCK: begin
          if (step_legal) begin
            dir_d   = step_up;
            par_d   = ~in_count[0];
            state_d = (state_q == ST_ACQ1) ? ST_ACQ2 : ST_LOCK;
            // Only a step taken from LOCK can report a mode change.
            if ((state_q == ST_LOCK) && ({dir_d, par_d} != {dir, par}))
              mode_chg_d = 1'b1;
          end else begin
            state_d   = ST_ACQ1;
            seq_err_d = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Registered outputs and last valid sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= '0;
      dir      <= 1'b0;
      par      <= 1'b0;
      locked   <= 1'b0;
      seq_err  <= 1'b0;
      mode_chg <= 1'b0;
    end else begin
      if (in_valid) prev_q <= in_count;
      dir      <= dir_d;
      par      <= par_d;
      locked   <= (state_d == ST_LOCK);
      seq_err  <= seq_err_d;
      mode_chg <= mode_chg_d;
    end
  end

`ifdef COUNT_SEQ_DECODER_ERRCNT_EN
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  // Saturating illegal-step counter, aligned with the seq_err pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              err_cnt <= '0;
    else if (seq_err_d && (err_cnt != ERR_MAX)) err_cnt <= ERR_W'(err_cnt + 1'b1);
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_count_seq_decoder.sv
// Self-checking bench for count_seq_decoder: a streak-based behavioural
// model checked every cycle, plus directed literal expectations.
module tb_count_seq_decoder;

`ifdef COUNT_SEQ_DECODER_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_count = 4'd0;
  logic       dir, par, locked, seq_err, mode_chg;
  logic [7:0] err_cnt;

  int total = 0;
  int bad = 0;

  count_seq_decoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_count (in_count),
    .dir      (dir),
    .par      (par),
    .locked   (locked),
    .seq_err  (seq_err),
    .mode_chg (mode_chg),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Model: lock == two consecutive legal steps since the last illegal one.
  bit m_have;
  int m_prev, m_streak, m_err, m_d;
  bit m_dir, m_par, m_seq, m_chg, m_nd, m_np;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_have = 0; m_prev = 0; m_streak = 0; m_err = 0;
      m_dir = 0; m_par = 0; m_seq = 0; m_chg = 0;
    end else begin
      m_seq = 0;
      m_chg = 0;
      if (in_valid) begin
        if (m_have) begin
          m_d = (int'(in_count) - m_prev + 16) % 16;
          if (m_d == 1 || m_d == 2 || m_d == 14 || m_d == 15) begin
            m_nd = (m_d <= 2);
            m_np = ~in_count[0];
            if (m_streak >= 2 && (m_nd != m_dir || m_np != m_par)) m_chg = 1;
            m_dir = m_nd;
            m_par = m_np;
            if (m_streak < 2) m_streak++;
          end else begin
            m_streak = 0;
            m_seq = 1;
            if (m_err < 255) m_err++;
          end
        end
        m_have = 1;
        m_prev = int'(in_count);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_dir", int'(dir), int'(m_dir));
      check("cyc_par", int'(par), int'(m_par));
      check("cyc_locked", int'(locked), int'(m_streak == 2));
      check("cyc_seq_err", int'(seq_err), int'(m_seq));
      check("cyc_mode_chg", int'(mode_chg), int'(m_chg));
      check("cyc_err_cnt", int'(err_cnt), ERR_EN ? m_err : 0);
    end
  end

  // Drive one cycle of input; returns at the following negedge.
  task automatic step(input logic v, input logic [3:0] c);
    in_valid = v;
    in_count = c;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_dir", int'(dir), 0);
    check("rst_par", int'(par), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_seq_err", int'(seq_err), 0);
    check("rst_mode_chg", int'(mode_chg), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Up, odd lane, with an idle gap carrying a bogus value
    step(1, 4'd0);
    step(1, 4'd1);
    step(0, 4'd9);
    check("up_gap_noerr", int'(seq_err), 0);
    step(1, 4'd3);
    check("up_locked", int'(locked), 1);
    check("up_dir", int'(dir), 1);
    check("up_par", int'(par), 0);
    check("model_up_lock", m_streak, 2);
    step(1, 4'd5);
    check("up_seq_err", int'(seq_err), 0);

    // Down, even lane, wrap 0 -> 14
    do_reset();
    step(1, 4'd8); step(1, 4'd6); step(1, 4'd4);
    step(1, 4'd2); step(1, 4'd0); step(1, 4'd14);
    check("dn_locked", int'(locked), 1);
    check("dn_dir", int'(dir), 0);
    check("dn_par", int'(par), 1);
    check("dn_wrap_noerr", int'(seq_err), 0);

    // Lane change while locked
    do_reset();
    step(1, 4'd1); step(1, 4'd3); step(1, 4'd5);
    step(1, 4'd6);
    check("chg_pulse", int'(mode_chg), 1);
    check("chg_par", int'(par), 1);
    check("chg_dir", int'(dir), 1);
    check("model_chg", int'(m_chg), 1);
    step(0, 4'd0);
    check("chg_one_cycle", int'(mode_chg), 0);

    // Illegal step then relock
    do_reset();
    step(1, 4'd1); step(1, 4'd3); step(1, 4'd5);
    step(1, 4'd9);
    check("ill_seq_err", int'(seq_err), 1);
    check("ill_unlock", int'(locked), 0);
    check("ill_err_cnt", int'(err_cnt), ERR_EN ? 1 : 0);
    step(1, 4'd11);
    check("ill_seq_clear", int'(seq_err), 0);
    check("ill_acq", int'(locked), 0);
    step(1, 4'd13);
    check("relock", int'(locked), 1);

    // Reset mid-acquisition discards progress
    do_reset();
    step(1, 4'd1); step(1, 4'd3);
    do_reset();
    step(1, 4'd5); step(1, 4'd7);
    check("rst_mid_nolock", int'(locked), 0);
    check("rst_mid_errcnt", int'(err_cnt), 0);
    step(1, 4'd9);
    check("rst_mid_lock", int'(locked), 1);

    // Wrap-around steps in both directions, none illegal
    do_reset();
    step(1, 4'd13); step(1, 4'd15); step(1, 4'd1);
    check("wrap_up_lock", int'(locked), 1);
    step(1, 4'd15);
    check("wrap_dn_noerr", int'(seq_err), 0);
    check("wrap_dn_dir", int'(dir), 0);
    step(1, 4'd0);
    check("wrap_up_dir", int'(dir), 1);
    check("wrap_err_cnt", int'(err_cnt), 0);

    // Saturation: 300 illegal steps
    do_reset();
    step(1, 4'd0);
    for (int i = 0; i < 300; i++) step(1, (i % 2 == 0) ? 4'd8 : 4'd0);
    check("sat_err_cnt", int'(err_cnt), ERR_EN ? 255 : 0);
    check("model_sat", m_err, 255);

    step(0, 4'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
